// File: rtl/store_write_buffer.sv
// Posted-store FIFO with in-order req/ack drain and a combinational load probe (RAW safety).
// Optional store coalescing into the youngest entry is enabled by defining WB_COALESCE_EN.
module store_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_valid,
    input  logic [ADDR_WIDTH-1:0]     push_addr,
    input  logic [DATA_WIDTH-1:0]     push_data,
    input  logic [DATA_WIDTH/8-1:0]   push_be,
    output logic                      push_ready,
    output logic                      mem_req,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_data,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    input  logic                      mem_ack,
    input  logic [ADDR_WIDTH-1:0]     ld_addr,
    output logic                      ld_hit,
    output logic [DATA_WIDTH-1:0]     ld_data,
    output logic                      ld_partial,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] WMASK = ~ADDR_WIDTH'(BW - 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0]   addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   addr_d [DEPTH];
    logic [DATA_WIDTH-1:0]   data_q [DEPTH];
    logic [DATA_WIDTH-1:0]   data_d [DEPTH];
    logic [BW-1:0]           be_q   [DEPTH];
    logic [BW-1:0]           be_d   [DEPTH];
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
    logic [BW-1:0]           mem_be_q, mem_be_d;

    logic [ADDR_WIDTH-1:0]   push_word, ld_word;
    logic                    merge, accept, alloc, pop;
    logic                    found;
    logic [PW-1:0]           hit_idx, probe_idx;

    assign push_word = push_addr & WMASK;
    assign ld_word   = ld_addr & WMASK;

`ifdef WB_COALESCE_EN
    logic [PW-1:0] young;
    assign young = wr_ptr_q - PW'(1);
    // The head already presented to memory must not change under an outstanding request.
    assign merge = push_valid && (count_q != '0) && (addr_q[young] == push_word)
                   && !(state_q == REQ && count_q == CW'(1));
`else
    assign merge = 1'b0;
`endif

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign push_ready = !full || merge;
    assign accept     = push_valid && push_ready;
    assign alloc      = accept && !merge;
    assign pop        = (state_q == REQ) && mem_ack;

    assign count    = count_q;
    assign mem_req  = (state_q == REQ);
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_be   = mem_be_q;

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        be_d   = be_q;
        if (alloc) begin
            addr_d[wr_ptr_q] = push_word;
            data_d[wr_ptr_q] = push_data;
            be_d[wr_ptr_q]   = push_be;
        end
`ifdef WB_COALESCE_EN
        if (merge) begin
            for (int unsigned b = 0; b < BW; b++) begin
                if (push_be[b]) data_d[young][b*8 +: 8] = push_data[b*8 +: 8];
            end
            be_d[young] = be_q[young] | push_be;
        end
`endif
        wr_ptr_d = wr_ptr_q + PW'(alloc);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(alloc) - CW'(pop);

        // Next head is read from the post-update arrays so a same-edge push or merge is seen.
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_be_d   = mem_be_q;
        case (state_q)
            IDLE: if (!empty) begin
                state_d    = REQ;
                mem_addr_d = addr_d[rd_ptr_q];
                mem_data_d = data_d[rd_ptr_q];
                mem_be_d   = be_d[rd_ptr_q];
            end
            REQ: if (pop) begin
                if (count_d != '0) begin
                    mem_addr_d = addr_d[rd_ptr_d];
                    mem_data_d = data_d[rd_ptr_d];
                    mem_be_d   = be_d[rd_ptr_d];
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Walk oldest to youngest so the last match is the youngest.
    always_comb begin
        found     = 1'b0;
        hit_idx   = '0;
        probe_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            probe_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[probe_idx] == ld_word)) begin
                found   = 1'b1;
                hit_idx = probe_idx;
            end
        end
        ld_hit     = found && (be_q[hit_idx] == '1);
        ld_partial = found && (be_q[hit_idx] != '1);
        ld_data    = found ? data_q[hit_idx] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_be_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_be_q   <= mem_be_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            be_q       <= be_d;
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer; expectations follow WB_COALESCE_EN when defined.
module tb_store_write_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic [31:0] push_addr;
    logic [31:0] push_data;
    logic [3:0]  push_be;
    logic        push_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_partial;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int total = 0;
    int bad   = 0;

    store_write_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_addr(push_addr), .push_data(push_data), .push_be(push_be),
        .push_ready(push_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be), .mem_ack(mem_ack),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_partial(ld_partial),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        push_valid = 1'b1;
        push_addr  = a;
        push_data  = d;
        push_be    = be;
        tick();
        push_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; push_valid = 1'b0; push_addr = '0; push_data = '0; push_be = '0;
        mem_ack = 1'b0; ld_addr = '0;
        tick(); tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_ready", 64'(push_ready), 64'd1);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_hit", 64'(ld_hit), 64'd0);
        chk("rst_partial", 64'(ld_partial), 64'd0);
        rst = 1'b0;

        // single SW with ack tied high
        mem_ack = 1'b1;
        tick();
        chk("idle_ack_ignored", 64'(count), 64'd0);
        push(32'h100, 32'hDEADBEEF, 4'b1111);
        chk("sw_count1", 64'(count), 64'd1);
        chk("sw_req_not_yet", 64'(mem_req), 64'd0);
        tick();
        chk("sw_req", 64'(mem_req), 64'd1);
        chk("sw_addr", 64'(mem_addr), 64'h100);
        chk("sw_data", 64'(mem_data), 64'hDEADBEEF);
        chk("sw_be", 64'(mem_be), 64'hF);
        tick();
        chk("sw_drained", 64'(count), 64'd0);
        chk("sw_req_drop", 64'(mem_req), 64'd0);

        // fill to full with ack low, 5th push ignored, ordered drain
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) push(32'(4 * k), 32'hA0 + 32'(k), 4'b1111);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_ready", 64'(push_ready), 64'd0);
        push(32'h10, 32'hBAD, 4'b1111);
        chk("fifth_ignored", 64'(count), 64'd4);
        ld_addr = 32'h10;
        #1;
        chk("fifth_not_stored", 64'(ld_hit), 64'd0);
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("order_req", 64'(mem_req), 64'd1);
            chk("order_addr", 64'(mem_addr), 64'(4 * k));
            chk("order_data", 64'(mem_data), 64'(32'hA0 + 32'(k)));
            tick();
        end
        chk("order_empty", 64'(empty), 64'd1);
        chk("order_req_drop", 64'(mem_req), 64'd0);

        // SW then SB to the same word
        mem_ack = 1'b0;
        push(32'h20, 32'h11223344, 4'b1111);
        push(32'h21, 32'h0000AA00, 4'b0010);
        ld_addr = 32'h22;
        #1;
`ifdef WB_COALESCE_EN
        chk("sb_count", 64'(count), 64'd1);
        chk("sb_hit", 64'(ld_hit), 64'd1);
        chk("sb_partial", 64'(ld_partial), 64'd0);
        chk("sb_data", 64'(ld_data), 64'h1122AA44);
        chk("sb_mem_data", 64'(mem_data), 64'h1122AA44);
`else
        chk("sb_count", 64'(count), 64'd2);
        chk("sb_hit", 64'(ld_hit), 64'd0);
        chk("sb_partial", 64'(ld_partial), 64'd1);
        chk("sb_mem_data", 64'(mem_data), 64'h11223344);
`endif
        mem_ack = 1'b1;
        n = 0;
        while (!empty && n < 10) begin tick(); n++; end
        chk("sb_drain", 64'(empty), 64'd1);

        // full buffer with push+ack on the same edge, then push+ack at count 3
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) push(32'h200 + 32'(4 * k), 32'h200 + 32'(k), 4'b1111);
        chk("fa_full", 64'(full), 64'd1);
        push_valid = 1'b1; push_addr = 32'h300; push_data = 32'h55; push_be = 4'b1111;
        mem_ack = 1'b1;
        tick();
        chk("fa_rejected", 64'(count), 64'd3);
        chk("fa_next_addr", 64'(mem_addr), 64'h204);
        tick();
        push_valid = 1'b0;
        chk("fa_push_pop", 64'(count), 64'd3);
        chk("fa_addr2", 64'(mem_addr), 64'h208);
        tick();
        chk("fa_count2", 64'(count), 64'd2);
        chk("fa_addr3", 64'(mem_addr), 64'h20C);
        tick();
        chk("fa_addr4", 64'(mem_addr), 64'h300);
        chk("fa_data4", 64'(mem_data), 64'h55);
        tick();
        chk("fa_empty", 64'(count), 64'd0);
        chk("fa_req_drop", 64'(mem_req), 64'd0);

        // youngest match wins
        mem_ack = 1'b0;
        push(32'h40, 32'h1, 4'b1111);
        push(32'h40, 32'h2, 4'b1111);
        ld_addr = 32'h40;
        #1;
        chk("yw_hit", 64'(ld_hit), 64'd1);
        chk("yw_data", 64'(ld_data), 64'h2);
        ld_addr = 32'h44;
        #1;
        chk("nm_hit", 64'(ld_hit), 64'd0);
        chk("nm_partial", 64'(ld_partial), 64'd0);
        chk("nm_data", 64'(ld_data), 64'h0);
        push(32'h44, 32'h3, 4'b1111);
`ifdef WB_COALESCE_EN
        push(32'h48, 32'h4, 4'b1111);
`endif
        chk("pre_rst_count", 64'(count), 64'd3);
        chk("pre_rst_req", 64'(mem_req), 64'd1);

        // asynchronous reset mid-drain
        #2 rst = 1'b1;
        #1;
        chk("arst_req", 64'(mem_req), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        #1 rst = 1'b0;
        tick();
        mem_ack = 1'b1;
        push(32'h80, 32'hCAFEF00D, 4'b1111);
        ld_addr = 32'h80;
        #1;
        chk("post_hit", 64'(ld_hit), 64'd1);
        chk("post_ld_data", 64'(ld_data), 64'hCAFEF00D);
        tick();
        chk("post_req", 64'(mem_req), 64'd1);
        chk("post_addr", 64'(mem_addr), 64'h80);
        chk("post_data", 64'(mem_data), 64'hCAFEF00D);
        tick();
        chk("post_empty", 64'(empty), 64'd1);
        chk("post_req_drop", 64'(mem_req), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
